// File: rtl/apb_master_param.sv
// APB4 master bridging a valid/ready request port to a single APB slave.
// Back-to-back transfers skip IDLE; an optional wait-cycle timeout aborts hung ACCESS phases.
module apb_master_param #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic [CNT_W-1:0]    wait_q;
  logic [CNT_W-1:0]    wait_d;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;
  logic                accept;
  logic                timeout_hit;

  // A completing ACCESS frees the port in the same cycle so the next request can chain.
  assign req_ready   = (state_q == IDLE) || ((state_q == ACCESS) && pready);
  assign accept      = req_valid && req_ready;
  assign timeout_hit = TO_EN && (wait_q == CNT_LAST);
  assign wait_d      = wait_q + CNT_W'(1);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;

      // Accept only happens in IDLE or a completing ACCESS, both of which start a new SETUP.
      if (accept) begin
        pwrite_q <= req_write;
        paddr_q  <= req_addr;
        pwdata_q <= req_wdata;
        pstrb_q  <= req_write ? req_strb : '0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            penable_q     <= 1'b0;
            if (accept) begin
              state_q <= SETUP;
            end else begin
              psel_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (timeout_hit) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= IDLE;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_param.sv
// Bench for apb_master_param: directed and random transfers against a scripted APB slave,
// with responses (value and arrival cycle) checked by a queue scoreboard.
`timescale 1ns/1ps
module tb_apb_master_param;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strb = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waitC;
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            cyc;
  } rsp_t;

  txn_t slvQ[$];
  rsp_t expQ[$];
  txn_t cur;
  rsp_t monE;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  apb_master_param #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [SW-1:0] strb, input int waitC, input logic [DW-1:0] rdata,
                              input logic err);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb;
    t.waitC = waitC; t.rdata = rdata; t.err = err;
    return t;
  endfunction

  task automatic checkAttr();
    checkOutput("paddr", 32'(paddr), 32'(cur.addr));
    checkOutput("pwrite", 32'(pwrite), 32'(cur.wr));
    checkOutput("pstrb", 32'(pstrb), cur.wr ? 32'(cur.strb) : 32'd0);
    if (cur.wr) checkOutput("pwdata", 32'(pwdata), 32'(cur.wdata));
  endtask

  // Scripted slave: each transfer stalls waitC ACCESS cycles, then answers with its planned data.
  always @(negedge pclk) begin
    if (psel && !penable) begin
      if (slvQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_setup actual=setup required=no transfer at cycle %0d", cyc);
      end else begin
        cur = slvQ.pop_front();
      end
      k = 0;
      pready = 1'b0;
      pslverr = 1'($urandom);
      prdata = DW'($urandom);
      checkOutput("setup_req_ready", 32'(req_ready), 32'd0);
      checkAttr();
    end else if (psel && penable) begin
      checkAttr();
      if (k == cur.waitC) begin
        pready = 1'b1;
        prdata = cur.rdata;
        pslverr = cur.err;
      end else begin
        pready = 1'b0;
        prdata = DW'($urandom);
        pslverr = 1'($urandom);
      end
      k++;
    end else begin
      pready = 1'b0;
      pslverr = 1'b0;
    end
  end

  // Scoreboard monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge pclk) begin
    if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp actual=rsp_valid=1 required=no response at cycle %0d", cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("rsp_cycle", 32'(cyc), 32'(monE.cyc));
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(monE.rdata));
        checkOutput("rsp_err", 32'(rsp_err), 32'(monE.err));
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(monE.tmo));
      end
    end
  end

  task automatic applyStimulus(input txn_t t);
    int   n;
    bit   done;
    bit   tmo;
    rsp_t e;
    n = 0;
    done = 1'b0;
    @(negedge pclk);
    req_valid = 1'b1;
    req_write = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_strb  = t.strb;
    slvQ.push_back(t);
    while (!done && n < 64) begin
      @(posedge pclk);
      if (req_ready) begin
        done = 1'b1;
        tmo = (t.waitC >= TO);
        e.rdata = (tmo || t.wr) ? '0 : t.rdata;
        e.err   = tmo ? 1'b1 : t.err;
        e.tmo   = tmo;
        e.cyc   = tmo ? cyc + 2 + TO : cyc + 3 + t.waitC;
        expQ.push_back(e);
      end
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_accept actual=never accepted required=accepted within 64 cycles");
      req_valid = 1'b0;
    end
  endtask

  task automatic idleGap(input int g);
    if (g > 0) begin
      @(negedge pclk);
      req_valid = 1'b0;
      repeat (g - 1) @(negedge pclk);
    end
  endtask

  initial begin
    txn_t t;
    int   n;
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    checkOutput("rst_psel", 32'(psel), 32'd0);
    checkOutput("rst_penable", 32'(penable), 32'd0);
    checkOutput("rst_pwrite", 32'(pwrite), 32'd0);
    checkOutput("rst_paddr", 32'(paddr), 32'd0);
    checkOutput("rst_pwdata", 32'(pwdata), 32'd0);
    checkOutput("rst_pstrb", 32'(pstrb), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge pclk);
    presetn = 1'b1;

    applyStimulus(mk(1'b1, 8'h10, 8'h5A, 1'b1, 0, 8'hEE, 1'b0));
    idleGap(1);
    applyStimulus(mk(1'b0, 8'h20, 8'h00, 1'b1, 3, 8'hC3, 1'b0));
    idleGap(2);
    applyStimulus(mk(1'b1, 8'h30, 8'h11, 1'b1, 0, 8'h00, 1'b0));
    applyStimulus(mk(1'b0, 8'h31, 8'h00, 1'b0, 0, 8'h77, 1'b0));
    idleGap(1);
    applyStimulus(mk(1'b1, 8'h40, 8'hA5, 1'b1, 1, 8'h00, 1'b1));
    applyStimulus(mk(1'b0, 8'h41, 8'h00, 1'b0, 0, 8'h99, 1'b1));
    idleGap(1);
    applyStimulus(mk(1'b0, 8'h50, 8'h00, 1'b0, 10, 8'h12, 1'b0));
    applyStimulus(mk(1'b0, 8'h51, 8'h00, 1'b0, 2, 8'h34, 1'b0));

    for (int i = 0; i < 60; i++) begin
      t.wr    = 1'($urandom);
      t.addr  = AW'($urandom);
      t.wdata = DW'($urandom);
      t.strb  = SW'($urandom);
      t.waitC = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
      t.rdata = DW'($urandom);
      t.err   = ($urandom_range(0, 3) == 0);
      applyStimulus(t);
      idleGap(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2)));
    end

    @(negedge pclk);
    req_valid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    @(negedge pclk);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

    // Reset during a stalled ACCESS: the transfer vanishes without a response.
    applyStimulus(mk(1'b0, 8'h44, 8'h00, 1'b0, 10, 8'h00, 1'b0));
    @(negedge pclk);
    req_valid = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #2;
    checkOutput("pre_reset_psel", 32'(psel), 32'd1);
    checkOutput("pre_reset_penable", 32'(penable), 32'd1);
    presetn = 1'b0;
    #1;
    checkOutput("async_rst_psel", 32'(psel), 32'd0);
    checkOutput("async_rst_penable", 32'(penable), 32'd0);
    expQ.delete();
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      checkOutput("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    checkOutput("post_rst_psel", 32'(psel), 32'd0);
    checkOutput("post_rst_rsp_err", 32'(rsp_err), 32'd0);

    applyStimulus(mk(1'b1, 8'h66, 8'h3C, 1'b1, 1, 8'h00, 1'b0));
    @(negedge pclk);
    req_valid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    @(negedge pclk);
    checkOutput("final_drain_empty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still running required=finished before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
